controlpath_mkiii: RTL and testbench



---
 rtl/mkiii_pkg.sv | 44 ++++
 rtl/mkiii_decode.sv | 66 ++++++
 rtl/controlpath_mkiii.sv | 188 ++++++++++++++++++
 tb/tb_controlpath_mkiii.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mkiii_pkg.sv
// rtl/mkiii_pkg.sv - shared types, field positions and helpers for controlpath_mkiii
//
// Purpose : instruction class and FSM state enums, machine-code field bit
//           positions and the imm10 sign-extension helper.
// Ports   : none (package)
package mkiii_pkg;

    // Instruction class lives in [31:30]; CLS_NOP is the NOP encoding.
    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_I   = 2'b01,
        CLS_LI  = 2'b10,
        CLS_NOP = 2'b11
    } cls_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_WB   = 3'd3,
        ST_LIWB = 3'd4
    } state_t;

    localparam int CLS_HI = 31;
    localparam int CLS_LO = 30;
    localparam int FCN_HI = 29;
    localparam int FCN_LO = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 20;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 14;
    localparam int RS2_LO = 10;
    localparam int IMM_HI = 9;
    localparam int IMM_LO = 0;

    // Widest datapath the helper supports; callers truncate to DATA_W.
    localparam int SEXT_MAX_W = 64;

    function automatic logic [SEXT_MAX_W-1:0] sext_imm10(input logic [9:0] v);
        return {{(SEXT_MAX_W-10){v[9]}}, v};
    endfunction

endpackage

// File: rtl/mkiii_decode.sv
// rtl/mkiii_decode.sv - combinational field split, imm extension and index check
//
// Purpose : splits a 32-bit machine-code word into its fields, sign-extends
//           imm10 to DATA_W and flags whether every index the class uses is
//           below NUM_REGS.
// Ports   : instr  - machine-code word
//           cls    - instruction class
//           fcn    - ALU function field
//           rd/rs1/rs2 - register indices truncated to the register-file width
//           imm    - sign-extended immediate
//           legal  - all indices used by this class are in range
module mkiii_decode
    import mkiii_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [31:0]       instr,
    output cls_t              cls,
    output logic [4:0]        fcn,
    output logic [IDX_W-1:0]  rd,
    output logic [IDX_W-1:0]  rs1,
    output logic [IDX_W-1:0]  rs2,
    output logic [DATA_W-1:0] imm,
    output logic              legal
);

    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [9:0] imm10;
    logic       rd_ok;
    logic       rs1_ok;
    logic       rs2_ok;

    assign cls   = cls_t'(instr[CLS_HI:CLS_LO]);
    assign fcn   = instr[FCN_HI:FCN_LO];
    assign rd_f  = instr[RD_HI:RD_LO];
    assign rs1_f = instr[RS1_HI:RS1_LO];
    assign rs2_f = instr[RS2_HI:RS2_LO];
    assign imm10 = instr[IMM_HI:IMM_LO];

    assign rd_ok  = ({1'b0, rd_f}  < NREGS);
    assign rs1_ok = ({1'b0, rs1_f} < NREGS);
    assign rs2_ok = ({1'b0, rs2_f} < NREGS);

    assign rd  = rd_f[IDX_W-1:0];
    assign rs1 = rs1_f[IDX_W-1:0];
    assign rs2 = rs2_f[IDX_W-1:0];
    assign imm = DATA_W'(sext_imm10(imm10));

    // Only fields the class actually uses participate in the check.
    always_comb begin
        legal = 1'b1;
        case (cls)
            CLS_R:   legal = rd_ok && rs1_ok && rs2_ok;
            CLS_I:   legal = rd_ok && rs1_ok;
            CLS_LI:  legal = rd_ok;
            default: legal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controlpath_mkiii.sv
// rtl/controlpath_mkiii.sv - instruction sequencer driving shared-bus micro-operations
//
// Purpose : accepts machine-code words over valid/ready and steps them through
//           one bus micro-operation per cycle (register read/write, ALU operand
//           store/broadcast, immediate drive). Traps illegal register indices
//           and counts retired instructions.
// Ports   : clk, reset            - clock, asynchronous active-high reset
//           instr/instr_valid/instr_ready - instruction handshake
//           alu_function_sel, alu_store_1, alu_store_2, alu_broadcast - ALU control
//           register_index, register_read_enable, register_write_enable - register file control
//           imm, imm_EN           - immediate value and bus drive
//           illegal               - sticky illegal-index flag
//           retired               - retired-instruction counter
module controlpath_mkiii
    import mkiii_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instr,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    output logic [4:0]                  alu_function_sel,
    output logic                        alu_store_1,
    output logic                        alu_store_2,
    output logic                        alu_broadcast,
    output logic [$clog2(NUM_REGS)-1:0] register_index,
    output logic                        register_read_enable,
    output logic                        register_write_enable,
    output logic [DATA_W-1:0]           imm,
    output logic                        imm_EN,
    output logic                        illegal,
    output logic [CNT_W-1:0]            retired
);

    localparam int IDX_W = $clog2(NUM_REGS);

    cls_t              dec_cls;
    logic [4:0]        dec_fcn;
    logic [IDX_W-1:0]  dec_rd;
    logic [IDX_W-1:0]  dec_rs1;
    logic [IDX_W-1:0]  dec_rs2;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_legal;

    mkiii_decode #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .instr (instr),
        .cls   (dec_cls),
        .fcn   (dec_fcn),
        .rd    (dec_rd),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .imm   (dec_imm),
        .legal (dec_legal)
    );

    state_t            state_q,   state_d;
    logic              is_imm_q,  is_imm_d;
    logic [4:0]        fcn_q,     fcn_d;
    logic [IDX_W-1:0]  rd_q,      rd_d;
    logic [IDX_W-1:0]  rs1_q,     rs1_d;
    logic [IDX_W-1:0]  rs2_q,     rs2_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              accept;

    assign illegal = illegal_q;
    assign retired = retired_q;

    always_comb begin
        state_d   = state_q;
        is_imm_d  = is_imm_q;
        fcn_d     = fcn_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        alu_function_sel      = '0;
        alu_store_1           = 1'b0;
        alu_store_2           = 1'b0;
        alu_broadcast         = 1'b0;
        register_index        = '0;
        register_read_enable  = 1'b0;
        register_write_enable = 1'b0;
        imm                   = '0;
        imm_EN                = 1'b0;

        // Ready in the final step lets the next instruction issue back-to-back.
        instr_ready = (state_q == ST_IDLE) || (state_q == ST_WB) || (state_q == ST_LIWB);
        accept      = instr_valid && instr_ready;

        case (state_q)
            ST_LDA: begin
                state_d              = ST_LDB;
                alu_function_sel     = fcn_q;
                register_index       = rs1_q;
                register_read_enable = 1'b1;
                alu_store_1          = 1'b1;
            end
            ST_LDB: begin
                state_d          = ST_WB;
                alu_function_sel = fcn_q;
                alu_store_2      = 1'b1;
                if (is_imm_q) begin
                    imm_EN = 1'b1;
                    imm    = imm_q;
                end else begin
                    register_read_enable = 1'b1;
                    register_index       = rs2_q;
                end
            end
            ST_WB: begin
                state_d               = ST_IDLE;
                alu_function_sel      = fcn_q;
                alu_broadcast         = 1'b1;
                register_index        = rd_q;
                register_write_enable = 1'b1;
                retired_d             = retired_q + CNT_W'(1);
            end
            ST_LIWB: begin
                state_d               = ST_IDLE;
                alu_function_sel      = fcn_q;
                imm_EN                = 1'b1;
                imm                   = imm_q;
                register_index        = rd_q;
                register_write_enable = 1'b1;
                retired_d             = retired_q + CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new instruction overrides the default return to IDLE. Illegal and
        // NOP words are consumed without touching the captured registers.
        if (accept) begin
            if (dec_cls == CLS_NOP) begin
                state_d = ST_IDLE;
            end else if (!dec_legal) begin
                illegal_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                is_imm_d = (dec_cls == CLS_I);
                fcn_d    = dec_fcn;
                rd_d     = dec_rd;
                rs1_d    = dec_rs1;
                rs2_d    = dec_rs2;
                imm_d    = dec_imm;
                state_d  = (dec_cls == CLS_LI) ? ST_LIWB : ST_LDA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            is_imm_q  <= 1'b0;
            fcn_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_imm_q  <= is_imm_d;
            fcn_q     <= fcn_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_controlpath_mkiii.sv
// tb/tb_controlpath_mkiii.sv - self-checking bench for controlpath_mkiii
module tb_controlpath_mkiii;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic        rd_en;
        logic        st1;
        logic        st2;
        logic        bc;
        logic        we;
        logic        imm_en;
        logic [3:0]  idx;
        logic [31:0] imm;
        logic [4:0]  fcn;
        logic        last;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  alu_function_sel;
    logic        alu_store_1;
    logic        alu_store_2;
    logic        alu_broadcast;
    logic [3:0]  register_index;
    logic        register_read_enable;
    logic        register_write_enable;
    logic [31:0] imm;
    logic        imm_EN;
    logic        illegal;
    logic [3:0]  retired;

    controlpath_mkiii #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .alu_function_sel      (alu_function_sel),
        .alu_store_1           (alu_store_1),
        .alu_store_2           (alu_store_2),
        .alu_broadcast         (alu_broadcast),
        .register_index        (register_index),
        .register_read_enable  (register_read_enable),
        .register_write_enable (register_write_enable),
        .imm                   (imm),
        .imm_EN                (imm_EN),
        .illegal               (illegal),
        .retired               (retired)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    op_t  q[$];
    int   retired_m = 0;
    logic illegal_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
        return (q.size() == 0) || q[0].last;
    endfunction

    // Expands one accepted word into its per-cycle bus operations.
    task automatic expand(input logic [31:0] w);
        logic [1:0]  cls;
        logic [4:0]  fcn, rd, rs1, rs2;
        logic [31:0] sx;
        logic        bad;
        op_t         o;
        cls = w[31:30];
        fcn = w[29:25];
        rd  = w[24:20];
        rs1 = w[19:15];
        rs2 = w[14:10];
        sx  = {{22{w[9]}}, w[9:0]};
        bad = (cls == 2'd0 && (rd >= NUM_REGS || rs1 >= NUM_REGS || rs2 >= NUM_REGS)) ||
              (cls == 2'd1 && (rd >= NUM_REGS || rs1 >= NUM_REGS)) ||
              (cls == 2'd2 && rd >= NUM_REGS);
        if (cls == 2'd3) return;
        if (bad) begin
            illegal_m = 1'b1;
            return;
        end
        if (cls == 2'd2) begin
            o = '0; o.imm_en = 1; o.we = 1; o.idx = rd[3:0]; o.imm = sx; o.fcn = fcn; o.last = 1;
            q.push_back(o);
            return;
        end
        o = '0; o.rd_en = 1; o.st1 = 1; o.idx = rs1[3:0]; o.fcn = fcn;
        q.push_back(o);
        o = '0; o.st2 = 1; o.fcn = fcn;
        if (cls == 2'd1) begin
            o.imm_en = 1; o.imm = sx;
        end else begin
            o.rd_en = 1; o.idx = rs2[3:0];
        end
        q.push_back(o);
        o = '0; o.bc = 1; o.we = 1; o.idx = rd[3:0]; o.fcn = fcn; o.last = 1;
        q.push_back(o);
    endtask

    task automatic check_outputs();
        op_t e;
        e = (q.size() > 0) ? q[0] : '0;
        chk("ready",     instr_ready,           model_ready());
        chk("fcn",       alu_function_sel,      e.fcn);
        chk("store_1",   alu_store_1,           e.st1);
        chk("store_2",   alu_store_2,           e.st2);
        chk("broadcast", alu_broadcast,         e.bc);
        chk("index",     register_index,        e.idx);
        chk("read_en",   register_read_enable,  e.rd_en);
        chk("write_en",  register_write_enable, e.we);
        chk("imm",       imm,                   e.imm);
        chk("imm_en",    imm_EN,                e.imm_en);
        chk("one_drv",   64'(register_read_enable + imm_EN + alu_broadcast) <= 1, 1);
        chk("illegal",   illegal,               illegal_m);
        chk("retired",   retired,               64'(retired_m));
    endtask

    // Drives one cycle starting at posedge+1, then checks at the next posedge+1.
    task automatic cycle(input logic v, input logic [31:0] w);
        logic acc;
        instr_valid = v;
        instr       = w;
        acc         = v && model_ready();
        @(posedge clk);
        if (q.size() > 0) begin
            if (q[0].last) retired_m = (retired_m + 1) % 16;
            void'(q.pop_front());
        end
        if (acc) expand(w);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        #1;
        q.delete();
        retired_m = 0;
        illegal_m = 1'b0;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] enc(input logic [1:0] c, input logic [4:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [9:0] i10);
        return {c, f, rd, rs1, rs2, i10};
    endfunction

    function automatic logic [4:0] rand_idx();
        return ($urandom_range(0, 99) < 6) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    endfunction

    initial begin
        do_reset();
        chk("rst_ready", instr_ready, 1);
        chk("rst_retired", retired, 0);

        cycle(1, enc(2'b00, 5'd3, 5'd4, 5'd1, 5'd2, 10'd0));
        chk("r_lda_idx", register_index, 1);
        chk("r_lda_fcn", alu_function_sel, 3);
        cycle(0, '0);
        chk("r_ldb_idx", register_index, 2);
        cycle(0, '0);
        chk("r_wb_we", register_write_enable, 1);
        cycle(0, '0);
        chk("r_retired", retired, 1);

        cycle(1, enc(2'b01, 5'd7, 5'd6, 5'd5, 5'd0, 10'h3FF));
        cycle(0, '0);
        chk("i_ldb_imm", imm, 32'hFFFF_FFFF);
        chk("i_ldb_rd_en", register_read_enable, 0);
        cycle(0, '0);
        chk("i_wb_idx", register_index, 6);
        cycle(0, '0);

        for (int i = 0; i < 4; i++) begin
            cycle(1, enc(2'b10, 5'd0, 5'(i + 1), 5'd0, 5'd0, 10'(i + 5)));
            chk("li_imm", imm, 64'(i + 5));
            chk("li_ready", instr_ready, 1);
        end
        cycle(0, '0);
        chk("li_retired", retired, 6);

        cycle(1, enc(2'b00, 5'd1, 5'd20, 5'd1, 5'd2, 10'd0));
        chk("ill_flag", illegal, 1);
        cycle(1, enc(2'b10, 5'd0, 5'd3, 5'd0, 5'd0, 10'd9));
        cycle(0, '0);
        chk("ill_next_retired", retired, 7);

        cycle(1, enc(2'b00, 5'd2, 5'd3, 5'd4, 5'd5, 10'd0));
        cycle(0, '0);
        do_reset();
        chk("rst_mid_retired", retired, 0);
        cycle(0, '0);
        chk("rst_mid_we", register_write_enable, 0);

        for (int i = 0; i < 17; i++) cycle(1, enc(2'b10, 5'd1, 5'd2, 5'd0, 5'd0, 10'(i)));
        cycle(0, '0);
        chk("wrap_retired", retired, 1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = enc(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), rand_idx(), rand_idx(),
                    rand_idx(), 10'($urandom_range(0, 1023)));
            cycle($urandom_range(0, 9) < 7, w);
            if (n == 200) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
